fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Write-side arbiter for the FIFO memory and write-pointer logic, in the write clock domain. Up to NREQ producers present words with a valid/ready handshake. The arbiter selects one producer per cycle by round-robin, drives the shared write-data bus and the write-enable, and honours the FIFO full flag. Optional packet/burst locking keeps one producer's beats contiguous in the FIFO.

## Interface
- DATASIZE, 8: word width; matches FIFO memory data width
- NREQ, 4: number of requesters, 2..16
- MAXBURST, 4: maximum consecutive beats per grant, >= 1; 1 = pure per-beat round-robin
- wclk  input  1  write-domain clock; all state updates on rising edge
- wrst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  requester i has a word
- req_last  input  NREQ  requester i's current word ends its packet
- req_data  input  NREQ*DATASIZE  requester i word at bits [i*DATASIZE +: DATASIZE]
- req_ready  output  NREQ  word i accepted this cycle when req_valid[i] & req_ready[i]
- wfull  input  1  FIFO full flag from the write-pointer logic
- winc  output  1  write enable; drives memory wclken and write-pointer increment
- wdata  output  DATASIZE  selected word to memory
- gnt  output  NREQ  one-hot current selection; all zero if none
- locked  output  1  burst lock held
- stall  output  1  a requester is selected but wfull blocks it

## Operation
- Registered state: rr_ptr (index of last requester served), lock, owner (index), beat (0..MAXBURST-1).
- Selection, combinational each cycle:
  - If lock = 1, sel = owner, regardless of req_valid[owner].
  - Otherwise sel = first i with req_valid[i] = 1, scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - If lock = 0 and no valid, there is no selection.
- gnt[sel] = 1 only if req_valid[sel] = 1. While locked with owner valid low, gnt = 0, giving a bubble; other requesters are not served.
- req_ready[i] = gnt[i] & ~wfull.
- winc = |(req_valid & req_ready).
- wdata = req_data of sel when gnt is nonzero, else 0.
- stall = (|gnt) & wfull.
- On a transfer (winc = 1) of requester s:
  - Burst ends if req_last[s] = 1 or beat = MAXBURST-1. Then lock <= 0, beat <= 0, rr_ptr <= s.
  - Otherwise lock <= 1, owner <= s, beat <= beat+1.
- No transfer (no valid, wfull, or locked bubble): all state holds.
- MAXBURST = 1: the burst always ends after one beat; lock never sets.
- req_last is ignored on non-transfer cycles.
- A requester must hold req_valid/req_data/req_last stable until accepted (standard valid/ready). The arbiter does not check this.

## Timing
- Zero-cycle latency: word accepted in cycle N is written to memory at the wclk edge ending cycle N (winc and wdata combinational from inputs and state).
- Reset (wrst_n low, asynchronous): rr_ptr = NREQ-1 (requester 0 has first priority), lock = 0, owner = 0, beat = 0. gnt, req_ready, winc, wdata, stall, locked are all 0 while reset is asserted, regardless of inputs.
- Reset mid-burst abandons the lock. The first transfer after release goes to the lowest-index valid requester.
- wfull rising while locked: lock, owner and beat hold. The burst resumes with the same owner when wfull drops.
- Simultaneous last beat and other requesters valid: the next cycle selects from rr_ptr+1 = s+1, with no idle cycle.
- Width: beat is clog2(MAXBURST) bits, minimum 1. rr_ptr and owner are clog2(NREQ) bits. rr_ptr wraps NREQ-1 -> 0.
- No combinational path from wfull to lock/owner state except through the winc-qualified update.

## Test plan
- Reset then all four req_valid = 1, MAXBURST = 1, wfull = 0, req_last = 0 -> winc every cycle. gnt sequence is 0001, 0010, 0100, 1000, 0001. wdata matches each requester's word.
- MAXBURST = 4; req 1 sends 6 beats with last on beat 6, req 2 continuously valid -> gnt = req 1 for 4 beats with locked = 1 on beats 2-4. Then req 2 for 4 beats, then req 1 beats 5-6.
- Locked owner req 0 drops valid for 2 cycles mid-burst while req 3 is valid -> gnt = 0 and winc = 0 for those 2 cycles; req 3 not served. Burst continues when req 0 returns.
- wfull = 1 for 3 cycles with req 2 valid -> stall = 1, req_ready = 0, winc = 0, state unchanged. When wfull drops, req 2 is accepted in the same cycle.
- req 0 and req 3 valid, req_last = 1 on every word -> gnt alternates 0001/1000 each beat; lock never sets.
- Assert wrst_n low mid-burst (owner req 2, beat 2) -> all outputs 0 immediately. After release with all valid, the first gnt = 0001 and locked = 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bus between the producers, the arbiter and the FIFO write logic.
// The producer handshake, the FIFO full flag and the arbiter results share one bundle.
// "slave" is the arbiter's view. "master" is the view of whatever surrounds it:
// the producers plus the FIFO write-pointer logic.
interface fifo_write_arbiter_if #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
) ();
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_last;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic [NREQ-1:0]          gnt;
    logic                     locked;
    logic                     stall;

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, gnt, locked, stall
    );

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, gnt, locked, stall
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of the FIFO memory and write pointer.
// It picks one producer per cycle and drives winc/wdata combinationally
// (zero-latency acceptance). An optional burst lock keeps up to MAXBURST beats
// of one producer contiguous in the FIFO.
module fifo_write_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_write_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAXBURST - 1);
    localparam logic [PW-1:0] PTR_RESET = PW'(NREQ - 1);

    // Registered arbitration state
    logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0] owner_reg, owner_next;
    logic          lock_reg, lock_next;
    logic [BW-1:0] beat_reg, beat_next;

    // Combinational selection
    logic [PW-1:0] scan_try;
    logic [PW-1:0] scan_idx;
    logic          scan_found;
    logic [PW-1:0] sel_idx;
    logic          sel_valid;
    logic          burst_end;

    logic [NREQ-1:0]     gnt_int;
    logic [NREQ-1:0]     ready_int;
    logic [DATASIZE-1:0] data_masked [NREQ];
    logic [DATASIZE-1:0] wdata_int;
    logic                winc_int;

    // Round-robin scan: first valid requester after the one served last
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_try   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_try = PW'((int'(rr_ptr_reg) + k) % NREQ);
            if (!scan_found && bus.req_valid[scan_try]) begin
                scan_found = 1'b1;
                scan_idx   = scan_try;
            end
        end
    end

    // While locked the owner stays selected even if its valid is low, which
    // creates a bubble instead of letting another producer break the burst.
    assign sel_valid = lock_reg | scan_found;
    assign sel_idx   = lock_reg ? owner_reg : scan_idx;

    // Per-requester grant and data masking. Reset forces every grant to zero,
    // so all outputs derived from gnt are also zero while reset is asserted.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign gnt_int[gi]     = wrst_n & sel_valid & (sel_idx == PW'(gi)) & bus.req_valid[gi];
            assign ready_int[gi]   = gnt_int[gi] & ~bus.wfull;
            assign data_masked[gi] = gnt_int[gi] ? bus.req_data[gi*DATASIZE +: DATASIZE] : '0;
        end
    endgenerate

    // One-hot grant, so OR-ing the masked words yields the selected word or zero
    always_comb begin
        wdata_int = '0;
        for (int k = 0; k < NREQ; k++) begin
            wdata_int = wdata_int | data_masked[k];
        end
    end

    assign winc_int = |(bus.req_valid & ready_int);

    assign bus.gnt       = gnt_int;
    assign bus.req_ready = ready_int;
    assign bus.winc      = winc_int;
    assign bus.wdata     = wdata_int;
    assign bus.stall     = (|gnt_int) & bus.wfull;
    assign bus.locked    = lock_reg & wrst_n;

    // Next-state logic: state only moves on an actual write. wfull reaches
    // the state solely through winc.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        lock_next   = lock_reg;
        beat_next   = beat_reg;
        burst_end   = bus.req_last[sel_idx] | (beat_reg == BEAT_LAST);
        if (winc_int) begin
            if (burst_end) begin
                lock_next   = 1'b0;
                beat_next   = '0;
                rr_ptr_next = sel_idx;
            end else begin
                lock_next   = 1'b1;
                owner_next  = sel_idx;
                beat_next   = beat_reg + 1'b1;
            end
        end
    end

    // State register. Reset gives requester 0 first priority and drops any burst.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rr_ptr_reg <= PTR_RESET;
            owner_reg  <= '0;
            lock_reg   <= 1'b0;
            beat_reg   <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            lock_reg   <= lock_next;
            beat_reg   <= beat_next;
        end
    end
endmodule
